// File: rtl/stage_fetch_if.sv
// stage_fetch_if -- instruction-memory request/response bus used by the fetch stage.
// master: fetch side (issues requests, consumes responses)
// slave : memory side (accepts requests, returns responses)
interface stage_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/stage_fetch.sv
// stage_fetch -- single-outstanding instruction fetch stage.
// Issues one request at a time, holds the returned instruction for the IF/ID
// stage until it is taken, and handles branch/trap redirects by discarding the
// response of any request that was in flight when the redirect arrived.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module stage_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         bj_en,
   input  logic [63:0]  bj_pc,
   input  logic         trap_en,
   input  logic [63:0]  trap_pc,
   stage_fetch_if.master imem,
   output logic         inst_valid,
   output logic [31:0]  inst_out,
   output logic [63:0]  pc_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [63:0]  perf_fetch_cnt,
   output logic [63:0]  perf_drop_cnt
`endif
);

   localparam logic [1:0]  S_REQ    = 2'd0;
   localparam logic [1:0]  S_WAIT   = 2'd1;
   localparam logic [1:0]  S_HOLD   = 2'd2;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic [1:0]  state_r;
   logic [1:0]  state_nx;
   logic [63:0] pc_r;
   logic [63:0] pc_nx;
   logic        drop_r;
   logic        drop_nx;
   logic        redirect_s;
   logic [63:0] target_s;
   logic        handshake_s;
   logic        capture_s;
   logic        leave_hold_s;
   logic        inst_valid_r;
   logic [31:0] inst_r;
   logic [63:0] pc_out_r;

   // Request is presented whenever the FSM sits in REQ; suppressed during reset.
   assign imem.imem_req_valid = (state_r == S_REQ) && !rst;
   assign imem.imem_req_addr  = pc_r;

   assign inst_valid = inst_valid_r;
   assign inst_out   = inst_r;
   assign pc_out     = pc_out_r;

   // Redirect strobe and target; a trap outranks a branch/jump.
   always_comb begin
      redirect_s  = trap_en | bj_en;
      handshake_s = (state_r == S_REQ) & imem.imem_req_ready;
      if (trap_en) begin
         target_s = trap_pc;
      end else begin
         target_s = bj_pc;
      end
   end

   // Next-state, next-pc and drop-flag decisions.
   always_comb begin
      state_nx  = state_r;
      pc_nx     = pc_r;
      drop_nx   = drop_r;
      capture_s = 1'b0;
      case (state_r)
         S_REQ: begin
            if (redirect_s) begin
               pc_nx = target_s;
            end else begin
               pc_nx = pc_r;
            end
            if (handshake_s) begin
               state_nx = S_WAIT;
               drop_nx  = redirect_s;
            end else begin
               state_nx = S_REQ;
            end
         end
         S_WAIT: begin
            if (imem.imem_rsp_valid) begin
               if (drop_r || redirect_s) begin
                  // response belongs to a redirected-away fetch: discard it
                  state_nx = S_REQ;
                  drop_nx  = 1'b0;
                  if (redirect_s) begin
                     pc_nx = target_s;
                  end else begin
                     pc_nx = pc_r;
                  end
               end else begin
                  state_nx  = S_HOLD;
                  capture_s = 1'b1;
               end
            end else if (redirect_s) begin
               pc_nx   = target_s;
               drop_nx = 1'b1;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_HOLD: begin
            if (redirect_s) begin
               pc_nx    = target_s;
               state_nx = S_REQ;
            end else if (!stall) begin
               pc_nx    = pc_r + 64'd4;
               state_nx = S_REQ;
            end else begin
               state_nx = S_HOLD;
            end
         end
         default: begin
            state_nx = S_REQ;
            drop_nx  = 1'b0;
         end
      endcase
      leave_hold_s = (state_r == S_HOLD) && (state_nx != S_HOLD);
   end

   // FSM, program counter and drop flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_REQ;
         pc_r    <= RESET_PC;
         drop_r  <= 1'b0;
      end else begin
         state_r <= state_nx;
         pc_r    <= pc_nx;
         drop_r  <= drop_nx;
      end
   end

   // Hold registers presented to IF/ID; read as NOP whenever not valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_valid_r <= 1'b0;
         inst_r       <= NOP_INST;
         pc_out_r     <= 64'd0;
      end else if (capture_s) begin
         inst_valid_r <= 1'b1;
         inst_r       <= imem.imem_rsp_data;
         pc_out_r     <= pc_r;
      end else if (leave_hold_s) begin
         inst_valid_r <= 1'b0;
         inst_r       <= NOP_INST;
      end else begin
         inst_valid_r <= inst_valid_r;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [63:0] perf_fetch_r;
   logic [63:0] perf_drop_r;

   assign perf_fetch_cnt = perf_fetch_r;
   assign perf_drop_cnt  = perf_drop_r;

   // Count HOLD->REQ transitions and responses thrown away after a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_r <= 64'd0;
         perf_drop_r  <= 64'd0;
      end else begin
         if (leave_hold_s) begin
            perf_fetch_r <= perf_fetch_r + 64'd1;
         end
         if ((state_r == S_WAIT) && imem.imem_rsp_valid && (drop_r || redirect_s)) begin
            perf_drop_r <= perf_drop_r + 64'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// tb_stage_fetch -- directed scenarios followed by randomized traffic, all
// checked against a transaction-level model of the fetch stage.
module tb_stage_fetch;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int PH_FETCH    = 0;   // request being offered to memory
   localparam int PH_INFLIGHT = 1;   // request accepted, response awaited
   localparam int PH_PRESENT  = 2;   // instruction offered to IF/ID

   logic        clk;
   logic        rst;
   logic        stall;
   logic        bj_en;
   logic [63:0] bj_pc;
   logic        trap_en;
   logic [63:0] trap_pc;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [63:0] pc_out;

   int errors = 0;
   int checks = 0;

   // model state
   int          m_phase;
   logic [63:0] m_pc;
   logic        m_drop;
   logic [63:0] m_pres_pc;
   logic [31:0] m_pres_inst;

   // memory environment state for the random phase
   logic        mem_pend;
   logic [63:0] mem_addr;
   int          mem_delay;

   stage_fetch_if bus ();

   stage_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .bj_en      (bj_en),
      .bj_pc      (bj_pc),
      .trap_en    (trap_en),
      .trap_pc    (trap_pc),
      .imem       (bus),
      .inst_valid (inst_valid),
      .inst_out   (inst_out),
      .pc_out     (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_3C00;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase     = PH_FETCH;
      m_pc        = RESET_PC;
      m_drop      = 1'b0;
      m_pres_pc   = 64'd0;
      m_pres_inst = NOP;
      mem_pend    = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst_out", 64'(inst_out), 64'(NOP));
      chk("rst_pc_out", pc_out, 64'd0);
   endtask

   task automatic compare_model();
      chk("req_valid", 64'(bus.imem_req_valid), 64'(m_phase == PH_FETCH));
      if (m_phase == PH_FETCH) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("inst_valid", 64'(inst_valid), 64'(m_phase == PH_PRESENT));
      chk("inst_out", 64'(inst_out), 64'((m_phase == PH_PRESENT) ? m_pres_inst : NOP));
      if (m_phase == PH_PRESENT) chk("pc_out", pc_out, m_pres_pc);
   endtask

   // One clock: drive inputs at the falling edge, predict, then compare at the next falling edge.
   task automatic step(input logic rdy, input logic stl,
                       input logic bj, input logic [63:0] bjp,
                       input logic tr, input logic [63:0] trp,
                       input logic rv, input logic [31:0] rd);
      logic        redir;
      logic [63:0] tgt;
      bus.imem_req_ready = rdy;
      bus.imem_rsp_valid = rv;
      bus.imem_rsp_data  = rd;
      stall   = stl;
      bj_en   = bj;
      bj_pc   = bjp;
      trap_en = tr;
      trap_pc = trp;
      redir = tr | bj;
      tgt   = tr ? trp : bjp;
      case (m_phase)
         PH_FETCH: begin
            if (rdy) begin
               m_phase = PH_INFLIGHT;
               m_drop  = redir;
            end
            if (redir) m_pc = tgt;
         end
         PH_INFLIGHT: begin
            if (rv) begin
               if (m_drop || redir) begin
                  m_phase = PH_FETCH;
                  m_drop  = 1'b0;
                  if (redir) m_pc = tgt;
               end else begin
                  m_phase     = PH_PRESENT;
                  m_pres_pc   = m_pc;
                  m_pres_inst = rd;
               end
            end else if (redir) begin
               m_pc   = tgt;
               m_drop = 1'b1;
            end
         end
         PH_PRESENT: begin
            if (redir) begin
               m_pc    = tgt;
               m_phase = PH_FETCH;
            end else if (!stl) begin
               m_pc    = m_pc + 64'd4;
               m_phase = PH_FETCH;
            end
         end
         default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic idle(input logic rdy);
      step(rdy, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 32'd0);
   endtask

   task automatic respond(input logic stl, input logic [31:0] rd);
      step(1'b0, stl, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, rd);
   endtask

   task automatic branch(input logic rdy, input logic [63:0] tgt);
      step(rdy, 1'b0, 1'b1, tgt, 1'b0, 64'd0, 1'b0, 32'd0);
   endtask

   initial begin
      logic [31:0] held_inst;
      logic [63:0] held_pc;
      rst = 1'b1;
      stall = 1'b0; bj_en = 1'b0; bj_pc = 64'd0; trap_en = 1'b0; trap_pc = 64'd0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      model_reset();

      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      #1;
      chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("first_req_addr", bus.imem_req_addr, RESET_PC);

      // basic fetch, response two cycles after acceptance
      idle(1'b1);
      idle(1'b0);
      respond(1'b1, 32'h00A0_0093);
      chk("fetch_inst_valid", 64'(inst_valid), 64'd1);
      chk("fetch_pc_out", pc_out, 64'h0000_0000_8000_0000);
      chk("fetch_inst_out", 64'(inst_out), 64'h0000_0000_00A0_0093);

      // stall holds the instruction and blocks new requests
      held_inst = inst_out;
      held_pc   = pc_out;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 32'd0);
         chk("stall_inst", 64'(inst_out), 64'(held_inst));
         chk("stall_pc", pc_out, held_pc);
         chk("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
      end
      idle(1'b0);
      chk("next_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0004);

      // branch while waiting: response dropped, refetch from target
      idle(1'b1);
      branch(1'b0, 64'h0000_0000_8000_1000);
      respond(1'b0, 32'hDEAD_BEEF);
      chk("drop_inst_valid", 64'(inst_valid), 64'd0);
      chk("drop_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_1000);

      // memory not ready: request stays put, redirect moves it
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         chk("notready_valid", 64'(bus.imem_req_valid), 64'd1);
         chk("notready_addr", bus.imem_req_addr, 64'h0000_0000_8000_1000);
      end
      branch(1'b0, 64'h0000_0000_8000_2000);
      chk("req_redirect_addr", bus.imem_req_addr, 64'h0000_0000_8000_2000);

      // trap beats branch
      step(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_3000, 1'b1, 64'h0000_0000_8000_0100, 1'b0, 32'd0);
      chk("trap_priority", bus.imem_req_addr, 64'h0000_0000_8000_0100);

      // redirect in the same cycle as acceptance
      branch(1'b1, 64'h0000_0000_8000_0200);
      respond(1'b0, 32'h1111_1111);
      chk("hs_redirect_addr", bus.imem_req_addr, 64'h0000_0000_8000_0200);

      // redirect in the same cycle as the response
      idle(1'b1);
      step(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0300, 1'b0, 64'd0, 1'b1, 32'h2222_2222);
      chk("rsp_redirect_addr", bus.imem_req_addr, 64'h0000_0000_8000_0300);

      // redirect while presenting and stalled
      idle(1'b1);
      respond(1'b1, 32'h3333_3333);
      step(1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0400, 1'b0, 64'd0, 1'b0, 32'd0);
      chk("hold_redirect_valid", 64'(inst_valid), 64'd0);

      // two redirects while one request is outstanding
      idle(1'b1);
      branch(1'b0, 64'h0000_0000_8000_0500);
      branch(1'b0, 64'h0000_0000_8000_0600);
      respond(1'b0, 32'h4444_4444);
      chk("double_redirect_addr", bus.imem_req_addr, 64'h0000_0000_8000_0600);
      idle(1'b1);
      respond(1'b1, 32'h5555_5555);
      chk("after_double_inst", 64'(inst_out), 64'h0000_0000_5555_5555);

      // stray responses while presenting and while requesting are ignored
      respond(1'b1, 32'h6666_6666);
      chk("stray_hold_inst", 64'(inst_out), 64'h0000_0000_5555_5555);
      idle(1'b0);
      respond(1'b0, 32'h7777_7777);
      chk("stray_req_valid", 64'(inst_valid), 64'd0);

      // pc wraps at 2^64
      step(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'd0);
      idle(1'b1);
      respond(1'b0, 32'h0000_0013);
      chk("wrap_pc_out", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
      idle(1'b0);
      chk("wrap_req_addr", bus.imem_req_addr, 64'd0);

      // reset in the middle of a transaction
      idle(1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      chk("rerst_req_addr", bus.imem_req_addr, RESET_PC);
      respond(1'b0, 32'h8888_8888);
      chk("rerst_stale_rsp", 64'(inst_valid), 64'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic        rdy, stl, bj, tr, rv, accept;
         logic [63:0] bjp, trp, acc_addr;
         logic [31:0] rd;
         int          r;
         rdy = ($urandom % 4) != 0;
         stl = ($urandom % 3) == 0;
         r   = $urandom % 16;
         bj  = (r == 0) || (r == 2);
         tr  = (r == 1) || (r == 2);
         bjp = 64'h0000_0000_8000_0000 + 64'(($urandom % 256) * 4);
         trp = 64'h0000_0000_9000_0000 + 64'(($urandom % 64) * 4);
         if (mem_pend) begin
            if (mem_delay == 0) begin
               rv = 1'b1;
               rd = mem_word(mem_addr);
               mem_pend = 1'b0;
            end else begin
               rv = 1'b0;
               rd = $urandom;
               mem_delay--;
            end
         end else begin
            rv = ($urandom % 16) == 0;
            rd = $urandom;
         end
         accept   = (m_phase == PH_FETCH) && rdy;
         acc_addr = m_pc;
         step(rdy, stl, bj, bjp, tr, trp, rv, rd);
         if (accept) begin
            mem_pend  = 1'b1;
            mem_addr  = acc_addr;
            mem_delay = $urandom % 3;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000; first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall  input  1  downstream IF/ID stage cannot accept; presented instruction SHALL be held.
REQ-005 SHALL have port bj_en  input  1  branch/jump redirect strobe, one cycle.
REQ-006 SHALL have port bj_pc  input  64  branch/jump target.
REQ-007 SHALL have port trap_en  input  1  trap redirect strobe, one cycle.
REQ-008 SHALL have port trap_pc  input  64  trap vector.
REQ-009 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-010 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port imem_req_addr  output  64  fetch address.
REQ-012 SHALL have port imem_rsp_valid  input  1  response data valid, one cycle per accepted request.
REQ-013 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-014 SHALL have port inst_valid  output  1  inst_out/pc_out valid for IF/ID capture.
REQ-015 SHALL have port inst_out  output  32  fetched instruction.
REQ-016 SHALL have port pc_out  output  64  address of inst_out.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, HOLD; at most one request outstanding.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; handshake (valid&ready) -> WAIT; imem_req_addr SHALL stay stable until accepted unless redirected.
REQ-019 WAIT: on imem_rsp_valid, capture imem_rsp_data and current pc into hold registers -> HOLD; inst_valid=1 starting the next cycle.
REQ-020 HOLD: inst_valid=1; if stall=0, pc <= pc+4 (64-bit, wrap at 2^64) and -> REQ; if stall=1, remain, outputs unchanged.
REQ-021 Redirect target SHALL be trap_pc if trap_en, else bj_pc if bj_en; trap_en has priority when both asserted.
REQ-022 Redirect in REQ (accepted or not that cycle): pc <= target; if handshake occurred same cycle, set drop flag and -> WAIT, else stay REQ.
REQ-023 Redirect in WAIT: pc <= target, set drop flag; the next imem_rsp_valid (even same cycle as redirect) SHALL be discarded, flag cleared, -> REQ.
REQ-024 Redirect in HOLD: hold contents discarded, inst_valid=0 next cycle, pc <= target, -> REQ, regardless of stall.
REQ-025 A second redirect while drop flag set SHALL only update pc; exactly one response is discarded per outstanding request.
REQ-026 inst_valid SHALL be 0 in REQ and WAIT; inst_out SHALL read 32'h0000_0013 (NOP) whenever inst_valid=0.
REQ-027 imem_rsp_valid in REQ or HOLD with drop flag clear is a protocol error and SHALL be ignored.

Reset
REQ-028 While rst=1: state REQ, pc=RESET_PC, drop flag 0, inst_valid=0, inst_out=32'h0000_0013, pc_out=0, imem_req_valid=0.
REQ-029 First cycle after rst deasserts, imem_req_valid=1 with imem_req_addr=RESET_PC.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request without a drop flag; responses arriving after reset in REQ are ignored per REQ-027.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs perf_fetch_cnt (64) counting HOLD->REQ transitions and perf_drop_cnt (64) counting discarded responses, both reset to 0, wrapping.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset release, ready=1, rsp 2 cycles later data 32'h00A00093 -> req addr 0x80000000, inst_valid=1 with pc_out=0x80000000, inst_out=32'h00A00093, next req addr 0x80000004.
REQ-034 stall=1 for 5 cycles in HOLD -> inst_out/pc_out constant, no new request; stall drop -> req addr pc+4 next cycle.
REQ-035 bj_en=1, bj_pc=0x80001000 in WAIT -> following response discarded (inst_valid stays 0), next req addr 0x80001000.
REQ-036 trap_en and bj_en same cycle, trap_pc=0x80000100 -> next req addr 0x80000100.
REQ-037 imem_req_ready=0 for 4 cycles -> imem_req_valid=1 and addr stable throughout; redirect during that -> addr switches to target next cycle.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC, response consumed -> next req addr 0x0 (wrap).
